// File: rtl/mandelbrot_job_scheduler_if.sv
// -----------------------------------------------------------------------------
// mandelbrot_job_scheduler_if
// Job bus between the Mandelbrot job scheduler and its iterator engines.
//
// Signals:
//   job_valid    [NUM_ENG]  one-hot single-cycle issue strobe, one bit per engine
//   job_cx       [COORD_W]  real coordinate of the issued pixel (signed 4.x)
//   job_cy       [COORD_W]  imaginary coordinate of the issued pixel (signed 4.x)
//   job_col      [10]       pixel column of the issued job
//   job_row      [9]        pixel row of the issued job
//   job_max_iter [ITER_W]   iteration limit for the frame
//   eng_done     [NUM_ENG]  per-engine one-cycle pulse: job finished, engine idle
//
// Modports:
//   master  scheduler side (drives jobs, receives completions)
//   slave   engine side    (receives jobs, drives completions)
// -----------------------------------------------------------------------------
interface mandelbrot_job_scheduler_if #(
    parameter int NUM_ENG = 4,
    parameter int COORD_W = 27,
    parameter int ITER_W  = 10
);
    logic [NUM_ENG-1:0] job_valid;
    logic [COORD_W-1:0] job_cx;
    logic [COORD_W-1:0] job_cy;
    logic [9:0]         job_col;
    logic [8:0]         job_row;
    logic [ITER_W-1:0]  job_max_iter;
    logic [NUM_ENG-1:0] eng_done;

    modport master (
        output job_valid, job_cx, job_cy, job_col, job_row, job_max_iter,
        input  eng_done
    );

    modport slave (
        input  job_valid, job_cx, job_cy, job_col, job_row, job_max_iter,
        output eng_done
    );
endinterface

// File: rtl/mandelbrot_job_scheduler.sv
// -----------------------------------------------------------------------------
// mandelbrot_job_scheduler
// Walks a frame in raster order, generates each pixel's complex coordinate
// incrementally, and hands one job per cycle (at most) to the first idle
// iterator engine found round-robin from rr_ptr. Reports busy while a frame
// is in progress and pulses done when the frame (or an aborted frame) has
// fully drained.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   cfg_x0/cfg_y0 top-left coordinate (signed 4.(COORD_W-4)), latched at start
//   cfg_dx/cfg_dy per-column / per-row steps, latched at start
//   cfg_max_iter  iteration limit, latched at start
//   start         begins a frame (honoured only in IDLE)
//   abort         stops issuing in ISSUE, then drains outstanding jobs
//   jobs          engine job bus (master side)
//   busy          high whenever the scheduler is not IDLE
//   done          one-cycle pulse when the frame completes or an abort drains
// -----------------------------------------------------------------------------
module mandelbrot_job_scheduler #(
    parameter int NUM_ENG = 4,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COORD_W = 27,
    parameter int ITER_W  = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [COORD_W-1:0]        cfg_x0,
    input  logic [COORD_W-1:0]        cfg_y0,
    input  logic [COORD_W-1:0]        cfg_dx,
    input  logic [COORD_W-1:0]        cfg_dy,
    input  logic [ITER_W-1:0]         cfg_max_iter,
    input  logic                      start,
    input  logic                      abort,
    mandelbrot_job_scheduler_if.master jobs,
    output logic                      busy,
    output logic                      done
);
    localparam int PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int CND_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t state_reg, state_next;

    // Frame configuration shadows and raster walk state
    logic [COORD_W-1:0] x0_reg, dx_reg, dy_reg;
    logic [ITER_W-1:0]  max_iter_reg;
    logic [COORD_W-1:0] cx_reg, cy_reg;
    logic [9:0]         col_reg;
    logic [8:0]         row_reg;

    // Engine tracking
    logic [NUM_ENG-1:0] busy_mask_reg;
    logic [PTR_W-1:0]   rr_ptr_reg;

    // Registered job outputs
    logic [NUM_ENG-1:0] job_valid_reg;
    logic [COORD_W-1:0] job_cx_reg, job_cy_reg;
    logic [9:0]         job_col_reg;
    logic [8:0]         job_row_reg;

    logic               issue_fire;
    logic               any_idle;
    logic               row_end;
    logic               last_pixel;
    logic [PTR_W-1:0]   grant_idx;
    logic [CND_W-1:0]   cand;
    logic [NUM_ENG-1:0] grant_onehot;
    logic [NUM_ENG-1:0] mask_after_done;

    // Completions only clear bits that are set, so a stray eng_done on an
    // idle engine has no effect.
    assign mask_after_done = busy_mask_reg & ~jobs.eng_done;
    assign any_idle        = ~&busy_mask_reg;
    assign row_end         = (col_reg == 10'(H_RES - 1));
    assign last_pixel      = row_end && (row_reg == 9'(V_RES - 1));

    // Round-robin search: scan offsets from the highest down so the idle
    // engine closest to rr_ptr (offset 0 first) is the one left in grant_idx.
    always_comb begin
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_ENG - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_reg} + CND_W'(k);
            if (cand >= CND_W'(NUM_ENG)) begin
                cand = cand - CND_W'(NUM_ENG);
            end
            if (!busy_mask_reg[cand[PTR_W-1:0]]) begin
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENG; gi++) begin : g_grant
            assign grant_onehot[gi] = issue_fire && (grant_idx == PTR_W'(gi));
        end
    endgenerate

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_ISSUE;
            S_ISSUE: begin
                if (abort) begin
                    state_next = S_DRAIN;
                end else if (issue_fire && last_pixel) begin
                    state_next = S_DRAIN;
                end
            end
            // Looking through this cycle's completions lets done follow the
            // final eng_done by exactly one cycle.
            S_DRAIN: if (mask_after_done == '0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        issue_fire = 1'b0;
        case (state_reg)
            S_ISSUE: begin
                busy       = 1'b1;
                issue_fire = !abort && any_idle;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: engine tracking, raster walk and registered job outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_reg        <= '0;
            dx_reg        <= '0;
            dy_reg        <= '0;
            max_iter_reg  <= '0;
            cx_reg        <= '0;
            cy_reg        <= '0;
            col_reg       <= '0;
            row_reg       <= '0;
            busy_mask_reg <= '0;
            rr_ptr_reg    <= '0;
            job_valid_reg <= '0;
            job_cx_reg    <= '0;
            job_cy_reg    <= '0;
            job_col_reg   <= '0;
            job_row_reg   <= '0;
        end else begin
            busy_mask_reg <= mask_after_done | grant_onehot;
            job_valid_reg <= grant_onehot;

            if (issue_fire) begin
                job_cx_reg  <= cx_reg;
                job_cy_reg  <= cy_reg;
                job_col_reg <= col_reg;
                job_row_reg <= row_reg;
                rr_ptr_reg  <= (grant_idx == PTR_W'(NUM_ENG - 1)) ? '0 : grant_idx + 1'b1;
                // Coordinate adds wrap modulo 2^COORD_W by construction.
                if (row_end) begin
                    col_reg <= '0;
                    cx_reg  <= x0_reg;
                    row_reg <= row_reg + 9'd1;
                    cy_reg  <= cy_reg + dy_reg;
                end else begin
                    col_reg <= col_reg + 10'd1;
                    cx_reg  <= cx_reg + dx_reg;
                end
            end

            if ((state_reg == S_IDLE) && start) begin
                x0_reg       <= cfg_x0;
                dx_reg       <= cfg_dx;
                dy_reg       <= cfg_dy;
                max_iter_reg <= cfg_max_iter;
                cx_reg       <= cfg_x0;
                cy_reg       <= cfg_y0;
                col_reg      <= '0;
                row_reg      <= '0;
            end
        end
    end

    assign jobs.job_valid    = job_valid_reg;
    assign jobs.job_cx       = job_cx_reg;
    assign jobs.job_cy       = job_cy_reg;
    assign jobs.job_col      = job_col_reg;
    assign jobs.job_row      = job_row_reg;
    assign jobs.job_max_iter = max_iter_reg;
endmodule
